eth_rx_buf_writer: RTL and testbench
====================================

ETH_RX_BUF_WRITER -- requirements
Module: eth_rx_buf_writer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i input 1 (rising-edge clock, the RX buffer write-port clock); rst_ni input 1 (synchronous, active-low reset).
REQ-002 Ports SHALL be, one per line, as follows:
- rx_data_i input 8: received byte.
- rx_valid_i input 1: byte valid; no backpressure.
- rx_last_i input 1: last byte of frame.
- rx_err_i input 1: frame error, sampled with rx_last_i.
- mem_en_o output 1: buffer byte-port enable.
- mem_we_o output 1: buffer byte-port write enable.
- mem_addr_o output 11: buffer byte address.
- mem_data_o output 8: buffer write byte.
- rd_ptr_i input 12: consumer release pointer, already synchronized to clk_i; bit 11 is the wrap bit.
- desc_valid_o output 1: frame descriptor valid.
- desc_ready_i input 1: descriptor accepted.
- desc_start_o output 11: first byte address of the frame, always word aligned.
- desc_len_o output 11: frame length in bytes.
- drop_cnt_o output 16: dropped-frame count.

Function
REQ-003 The block SHALL keep a 12-bit speculative write pointer wr_ptr and a 12-bit frame start pointer sof_ptr; the buffer address SHALL be ptr[10:0], a 2048-byte ring.
REQ-004 Free bytes SHALL be 2048 - (wr_ptr - rd_ptr_i) modulo 4096; the ring is full when this is 0 and empty when wr_ptr == rd_ptr_i.
REQ-005 The state machine SHALL have states IDLE, RECV, DROP and DESC.
REQ-006 IDLE with rx_valid_i=1 SHALL go to RECV and write the byte at sof_ptr; a single-byte frame (rx_last_i=1) SHALL be dropped as a runt.
REQ-007 An accepted byte in cycle N SHALL appear on mem_en_o=mem_we_o=1, mem_addr_o and mem_data_o in cycle N+1; both enables SHALL be 0 otherwise.
REQ-008 In RECV, each valid byte SHALL increment wr_ptr and the length count len by 1.
REQ-009 A byte arriving with free space 0, or with len already equal to MAX_FRAME_LEN, SHALL not be written; the state SHALL go to DROP, or directly to IDLE if rx_last_i=1.
REQ-010 DROP SHALL discard bytes until rx_last_i, then go to IDLE.
REQ-011 Every drop SHALL restore wr_ptr to sof_ptr and increment the drop count.
REQ-012 In RECV, rx_last_i with rx_err_i=1 or final len < MIN_FRAME_LEN SHALL be dropped and the state SHALL go to IDLE.
REQ-013 Otherwise rx_last_i SHALL load desc_start_o=sof_ptr[10:0] and desc_len_o=len, set desc_valid_o=1 in the next cycle and enter DESC.
REQ-014 On frame commit, wr_ptr and sof_ptr SHALL advance to the end of the frame rounded up to a multiple of 4; a pad that does not fit in free space SHALL still be skipped, because the consumer never releases past it.
REQ-015 In DESC, desc_valid_o SHALL stay asserted with stable fields until desc_valid_o && desc_ready_i, then return to IDLE in the next cycle.
REQ-016 rx_valid_i arriving while in DESC SHALL start a dropped frame (DROP, or an immediate drop if rx_last_i=1); the held descriptor SHALL stay unchanged.
REQ-017 rx_valid_i=0 in the middle of a frame SHALL cause a wait with no state change.
REQ-018 rd_ptr_i SHALL be used only for the free-space computation; the block never writes beyond it.

Reset
REQ-019 rst_ni=0 at a clock edge SHALL force IDLE, wr_ptr=sof_ptr=0, len=0, all mem_* outputs 0, desc_valid_o=0, desc_start_o=0, desc_len_o=0 and drop_cnt_o=0.
REQ-020 Reset mid-frame SHALL abandon the frame with no descriptor; input bytes up to the next frame start SHALL be ignored after reset release, by treating the first rx_valid_i after reset that is not at a frame start as DROP until rx_last_i.

Configuration
REQ-021 With ETH_RX_STATS_EN defined, drop_cnt_o SHALL count drops as a 16-bit value that saturates at 0xFFFF.
REQ-022 Without ETH_RX_STATS_EN, drop_cnt_o SHALL be tied to 0, the counter register SHALL be absent, and drop behaviour SHALL be otherwise identical.

Structure
REQ-023 Package eth_rx_pkg SHALL hold RX_BUF_BYTES=2048, MAX_FRAME_LEN=1522, MIN_FRAME_LEN=14 and the state enum rx_wr_state_e.
REQ-024 One sub-module, eth_rx_free_calc, SHALL be natural: combinational free-space and full computation from wr_ptr and rd_ptr_i.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- 64-byte good frame from reset -> writes to addresses 0..63, descriptor start=0, len=64; next frame starts at 64.
- 61-byte good frame -> len=61; next frame starts at address 64 (pad of 3).
- Frame with rx_err_i=1 on its last byte -> no descriptor, drop_cnt_o=1, wr_ptr back to 0.
- rd_ptr_i=0 and a 2100-byte stream -> drop at byte 2049, no descriptor, drop_cnt_o increments.
- desc_ready_i held 0 and a second frame arriving -> second frame dropped, first descriptor fields unchanged.
- Reset asserted at byte 30 of 64 -> all outputs 0; remaining 34 bytes ignored; next frame written at address 0.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared sizes, frame-length limits and FSM state type for the RX buffer writer
package eth_rx_pkg;
  localparam int RX_BUF_BYTES  = 2048;
  localparam int MAX_FRAME_LEN = 1522;
  localparam int MIN_FRAME_LEN = 14;
  typedef enum logic [1:0] {IDLE, RECV, DROP, DESC} rx_wr_state_e;
endpackage

// File: rtl/eth_rx_free_calc.sv
// eth_rx_free_calc: free space in the byte ring between the write pointer and the consumer release pointer
module eth_rx_free_calc
  import eth_rx_pkg::*;
(
  input  logic [11:0] wr_ptr_i,
  input  logic [11:0] rd_ptr_i,
  output logic        full_o
);
  logic [11:0] used, free;
  assign used   = wr_ptr_i - rd_ptr_i;
  assign free   = 12'(RX_BUF_BYTES) - used;
  assign full_o = free == 12'd0;
endmodule

// File: rtl/eth_rx_buf_writer.sv
// eth_rx_buf_writer: writes received bytes into a 2048-byte ring and emits one descriptor per good frame.
// Define ETH_RX_STATS_EN to get a saturating dropped-frame counter on drop_cnt_o (tied to 0 otherwise).
module eth_rx_buf_writer
  import eth_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_last_i,
  input  logic        rx_err_i,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [10:0] mem_addr_o,
  output logic [7:0]  mem_data_o,
  input  logic [11:0] rd_ptr_i,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic [10:0] desc_start_o,
  output logic [10:0] desc_len_o,
  output logic [15:0] drop_cnt_o
);
  rx_wr_state_e state_q;
  logic [11:0] wr_ptr_q, sof_ptr_q, aligned;
  logic [10:0] len_q, last_len, desc_start_q, desc_len_q, mem_addr_q;
  logic [7:0]  mem_data_q;
  logic mem_en_q, desc_valid_q, resync_q;
  logic full, accept, room, wr_en, bad_end, commit, drop_now, skip, pending;

  eth_rx_free_calc u_free (
    .wr_ptr_i (wr_ptr_q),
    .rd_ptr_i (rd_ptr_i),
    .full_o   (full)
  );

  // a byte belongs to the current frame unless we are resynchronising after reset
  assign accept   = rx_valid_i && ((state_q == IDLE && !resync_q) || state_q == RECV);
  assign room     = !full && (state_q == IDLE || len_q != 11'(MAX_FRAME_LEN));
  assign wr_en    = accept && room;
  assign last_len = (state_q == IDLE) ? 11'd1 : len_q + 11'd1;
  assign bad_end  = rx_err_i || last_len < 11'(MIN_FRAME_LEN);
  assign commit   = wr_en && rx_last_i && !bad_end;
  assign drop_now = (rx_valid_i && state_q == DESC) || (accept && (!room || (rx_last_i && bad_end)));
  assign skip     = rx_valid_i && state_q == IDLE && resync_q;
  assign pending  = desc_valid_q && !desc_ready_i;
  // committed frames end on a word boundary so the next frame start stays aligned
  assign aligned  = (wr_ptr_q + 12'd4) & ~12'd3;

  // FSM with registered write port, descriptor and pointer bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      sof_ptr_q    <= '0;
      len_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      desc_valid_q <= 1'b0;
      desc_start_q <= '0;
      desc_len_q   <= '0;
      resync_q     <= rx_valid_i ? !rx_last_i : (resync_q || state_q == RECV || state_q == DROP);
    end else begin
      mem_en_q <= wr_en;
      if (wr_en) begin
        mem_addr_q <= wr_ptr_q[10:0];
        mem_data_q <= rx_data_i;
        wr_ptr_q   <= wr_ptr_q + 12'd1;
        len_q      <= last_len;
      end
      if (rx_valid_i) resync_q <= 1'b0;
      if (!pending) desc_valid_q <= 1'b0;
      if (drop_now) wr_ptr_q <= sof_ptr_q;
      if (commit) begin
        wr_ptr_q     <= aligned;
        sof_ptr_q    <= aligned;
        desc_valid_q <= 1'b1;
        desc_start_q <= sof_ptr_q[10:0];
        desc_len_q   <= last_len;
      end
      if (commit) state_q <= DESC;
      else if (drop_now || skip) state_q <= rx_last_i ? (pending ? DESC : IDLE) : DROP;
      else if (wr_en) state_q <= RECV;
      else if (state_q == DROP && rx_valid_i && rx_last_i) state_q <= pending ? DESC : IDLE;
      else if (state_q == DESC && !pending) state_q <= IDLE;
    end
  end

`ifdef ETH_RX_STATS_EN
  logic [15:0] drop_cnt_q;
  // saturating count of dropped frames
  always_ff @(posedge clk_i) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else if (drop_now && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end
  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_en_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign desc_valid_o = desc_valid_q;
  assign desc_start_o = desc_start_q;
  assign desc_len_o   = desc_len_q;
endmodule

// File: tb/tb_eth_rx_buf_writer.sv
// tb_eth_rx_buf_writer: scoreboard bench for eth_rx_buf_writer (honours ETH_RX_STATS_EN for drop counts)
module tb_eth_rx_buf_writer;
  localparam int MAXL = 1522;
  localparam int MINL = 14;
  typedef struct packed {logic [10:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic [10:0] s; logic [10:0] l;} desc_t;

  logic clk = 0, rst_n = 0, rx_valid = 0, rx_last = 0, rx_err = 0, desc_ready = 1;
  logic [7:0] rx_data = 0;
  logic [11:0] rd = 0;
  logic mem_en, mem_we, desc_valid;
  logic [10:0] mem_addr, desc_start, desc_len;
  logic [7:0] mem_data;
  logic [15:0] drop_cnt;

  wr_t wq[$];
  desc_t dq[$];
  int checks = 0, passed = 0;
  int wr_m = 0, rd_m = 0, drops = 0;
  bit pend_m = 0;

  always #5 clk = ~clk;

  eth_rx_buf_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_last_i    (rx_last),
    .rx_err_i     (rx_err),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .rd_ptr_i     (rd),
    .desc_valid_o (desc_valid),
    .desc_ready_i (desc_ready),
    .desc_start_o (desc_start),
    .desc_len_o   (desc_len),
    .drop_cnt_o   (drop_cnt)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic int exp_drops();
`ifdef ETH_RX_STATS_EN
    return drops > 65535 ? 65535 : drops;
`else
    return 0;
`endif
  endfunction

  // Frame-level reference: bytes fit while below free space and the length cap;
  // a frame survives only if it fully fits, has no error and reaches the minimum length.
  function automatic void model_frame(input logic [7:0] data[$], input bit err);
    int n, room;
    n = data.size();
    if (pend_m) begin
      drops++;
      return;
    end
    room = 2048 - ((wr_m - rd_m) & 4095);
    if (room > MAXL) room = MAXL;
    for (int k = 0; k < n && k < room; k++) wq.push_back('{a: 11'((wr_m + k) & 2047), d: data[k]});
    if (n > room || err || n < MINL) drops++;
    else begin
      dq.push_back('{s: 11'(wr_m & 2047), l: 11'(n)});
      wr_m = ((wr_m + n + 3) / 4 * 4) & 4095;
    end
  endfunction

  // Monitor: every write-port strobe and every descriptor handshake is matched against the scoreboard
  always @(negedge clk) begin : mon
    wr_t w;
    desc_t x;
    if (mem_en || mem_we) begin
      chk("we_eq_en", int'(mem_we), int'(mem_en));
      if (wq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr=%0d data=%0d, expected no write", mem_addr, mem_data);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", int'(mem_addr), int'(w.a));
        chk("wr_data", int'(mem_data), int'(w.d));
      end
    end
    if (desc_valid && desc_ready) begin
      if (dq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_desc: start=%0d len=%0d, expected none", desc_start, desc_len);
      end else begin
        x = dq.pop_front();
        chk("desc_start", int'(desc_start), int'(x.s));
        chk("desc_len", int'(desc_len), int'(x.l));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [7:0] d, input logic l, input logic e);
    rx_valid = 1;
    rx_data  = d;
    rx_last  = l;
    rx_err   = e;
    tick(1);
    rx_valid = 0;
    rx_last  = 0;
    rx_err   = 0;
  endtask

  task automatic frame(input int n, input bit err, input bit gaps);
    logic [7:0] data[$];
    for (int i = 0; i < n; i++) data.push_back(8'($urandom));
    model_frame(data, err);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 7) == 0) tick(int'($urandom_range(1, 3)));
      put(data[i], i == n - 1, err && i == n - 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(2);
    chk("rst_mem", int'({mem_en, mem_we, mem_addr, mem_data}), 0);
    chk("rst_desc_valid", int'(desc_valid), 0);
    chk("rst_desc_fields", int'({desc_start, desc_len}), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    rst_n  = 1;
    wr_m   = 0;
    rd_m   = 0;
    rd     = 0;
    drops  = 0;
    pend_m = 0;
  endtask

  initial begin
    logic [7:0] part[$];
    int s0, n, sel, used;
    do_reset();
    tick(1);
    frame(64, 0, 0);
    tick(2);
    frame(61, 0, 1);
    tick(2);
    frame(40, 1, 1);
    tick(2);
    chk("err_drop_cnt", int'(drop_cnt), exp_drops());
    frame(20, 0, 0);
    tick(2);
    // descriptor held while a second frame arrives
    desc_ready = 0;
    s0 = wr_m & 2047;
    frame(20, 0, 0);
    tick(3);
    chk("held_valid", int'(desc_valid), 1);
    chk("held_start", int'(desc_start), s0);
    chk("held_len", int'(desc_len), 20);
    pend_m = 1;
    frame(30, 0, 1);
    tick(2);
    chk("held_valid2", int'(desc_valid), 1);
    chk("held_start2", int'(desc_start), s0);
    chk("held_len2", int'(desc_len), 20);
    chk("held_drop_cnt", int'(drop_cnt), exp_drops());
    pend_m = 0;
    desc_ready = 1;
    tick(2);
    chk("held_released", int'(desc_valid), 0);
    // reset at byte 30 of a 64-byte frame
    rd_m = wr_m;
    rd = 12'(rd_m);
    for (int i = 0; i < 64; i++) part.push_back(8'($urandom));
    for (int k = 0; k < 30; k++) wq.push_back('{a: 11'((wr_m + k) & 2047), d: part[k]});
    for (int i = 0; i < 30; i++) put(part[i], 0, 0);
    do_reset();
    for (int i = 30; i < 64; i++) put(part[i], i == 63, 0);
    tick(2);
    frame(64, 0, 0);
    tick(2);
    chk("post_rst_drop_cnt", int'(drop_cnt), exp_drops());
    // 2100-byte stream with rd_ptr held at 0: the ring fills at stream byte 2049
    do_reset();
    frame(1500, 0, 0);
    tick(2);
    frame(600, 0, 0);
    tick(2);
    chk("ovf_drop_cnt", int'(drop_cnt), exp_drops());
    chk("ovf_no_desc", int'(desc_valid), 0);
    // randomized traffic with a moving release pointer
    for (int f = 0; f < 40; f++) begin
      sel = int'($urandom_range(0, 9));
      n = sel == 0 ? 1 : sel == 1 ? MINL - 1 : sel == 2 ? MINL : sel == 3 ? MAXL : sel == 4 ? MAXL + 1 : int'($urandom_range(15, 300));
      if (sel == 3 || sel == 4 || $urandom_range(0, 1) == 0) rd_m = wr_m;
      rd = 12'(rd_m);
      frame(n, $urandom_range(0, 7) == 0, 1);
      tick(int'($urandom_range(1, 3)));
      used = (wr_m - rd_m) & 4095;
      rd_m = (rd_m + 4 * int'($urandom_range(0, used / 4))) & 4095;
      rd = 12'(rd_m);
    end
    tick(5);
    chk("final_drop_cnt", int'(drop_cnt), exp_drops());
    chk("writes_drained", wq.size(), 0);
    chk("descs_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
